// File: rtl/sram_block_master.sv
// ---------------------------------------------------------------------------
// sram_block_master
// Avalon-MM block mover: fills a destination range with a pattern word or
// copies a source range to a destination range, one word at a time.
//
// Parameters
//   ADDR_W          word-address width (also width of length / word counter)
//   DATA_W          data width, byteenable is DATA_W/8 bits
//
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   cmd_*           command handshake and fields (fill/src/dst/len/pattern)
//   abort           request to stop at the next word boundary
//   busy            job in progress (cycle after acceptance through DONE)
//   done            one-cycle completion pulse
//   aborted         qualifies done: job was cut short by abort
//   words_done      number of words written by the current/last job
//   avm_*           Avalon-MM master (fixed read latency of one cycle)
// ---------------------------------------------------------------------------
module sram_block_master #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_fill,
    input  logic [ADDR_W-1:0]   cmd_src,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [ADDR_W-1:0]   cmd_len,
    input  logic [DATA_W-1:0]   cmd_pattern,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [ADDR_W-1:0]   words_done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RDWAIT,
        ST_WR,
        ST_DONE
    } state_t;

    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_aborted;
    logic [ADDR_W-1:0]   r_words_done;
    logic [ADDR_W-1:0]   r_src_ptr;
    logic [ADDR_W-1:0]   r_dst_ptr;
    logic [ADDR_W-1:0]   r_remaining;
    logic                r_fill;
    logic                r_abort_pend;
    logic                r_read;
    logic                r_write;
    logic                r_cs;
    logic [ADDR_W-1:0]   r_address;
    // Data register: holds the fill pattern, or the word captured by the last read.
    logic [DATA_W-1:0]   r_writedata;

    logic                w_last;
    logic                w_stop;

    // Current write is the final one of the job.
    assign w_last = (r_remaining == ADDR_W'(1));
    // Abort seen now, or latched when the preceding read was accepted.
    assign w_stop = abort | r_abort_pend;

    // Main FSM; every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_words_done <= '0;
            r_src_ptr    <= '0;
            r_dst_ptr    <= '0;
            r_remaining  <= '0;
            r_fill       <= 1'b0;
            r_abort_pend <= 1'b0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_cs         <= 1'b0;
            r_address    <= '0;
            r_writedata  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_src_ptr    <= cmd_src;
                        r_dst_ptr    <= cmd_dst;
                        r_remaining  <= cmd_len;
                        r_fill       <= cmd_fill;
                        r_writedata  <= cmd_pattern;
                        r_words_done <= '0;
                        r_aborted    <= 1'b0;
                        r_abort_pend <= 1'b0;
                        r_cmd_ready  <= 1'b0;
                        r_busy       <= 1'b1;
                        if (cmd_len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (cmd_fill) begin
                            r_state   <= ST_WR;
                            r_write   <= 1'b1;
                            r_cs      <= 1'b1;
                            r_address <= cmd_dst;
                        end else begin
                            r_state   <= ST_RD;
                            r_read    <= 1'b1;
                            r_cs      <= 1'b1;
                            r_address <= cmd_src;
                        end
                    end
                end

                ST_RD: begin
                    if (!avm_waitrequest) begin
                        r_src_ptr    <= r_src_ptr + ADDR_W'(1);
                        r_abort_pend <= abort;
                        r_read       <= 1'b0;
                        r_cs         <= 1'b0;
                        r_state      <= ST_RDWAIT;
                    end
                end

                // Read data arrives exactly one cycle after the accepted read.
                ST_RDWAIT: begin
                    r_writedata <= avm_readdata;
                    r_write     <= 1'b1;
                    r_cs        <= 1'b1;
                    r_address   <= r_dst_ptr;
                    r_state     <= ST_WR;
                end

                ST_WR: begin
                    if (!avm_waitrequest) begin
                        r_dst_ptr    <= r_dst_ptr + ADDR_W'(1);
                        r_words_done <= r_words_done + ADDR_W'(1);
                        r_remaining  <= r_remaining - ADDR_W'(1);
                        if (w_last || w_stop) begin
                            r_state   <= ST_DONE;
                            r_write   <= 1'b0;
                            r_cs      <= 1'b0;
                            r_done    <= 1'b1;
                            r_aborted <= w_stop & ~w_last;
                        end else if (r_fill) begin
                            // Back-to-back fill writes: keep strobe, advance address.
                            r_address <= r_dst_ptr + ADDR_W'(1);
                        end else begin
                            r_state   <= ST_RD;
                            r_write   <= 1'b0;
                            r_read    <= 1'b1;
                            r_address <= r_src_ptr;
                        end
                    end
                end

                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_read      <= 1'b0;
                    r_write     <= 1'b0;
                    r_cs        <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign aborted        = r_aborted;
    assign words_done     = r_words_done;
    assign avm_address    = r_address;
    assign avm_chipselect = r_cs;
    assign avm_read       = r_read;
    assign avm_write      = r_write;
    assign avm_byteenable = {BE_W{1'b1}};
    assign avm_writedata  = r_writedata;

endmodule

// File: doc/sram_block_master.md
SRAM_BLOCK_MASTER -- requirements
Module: sram_block_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word-address width of the Avalon-MM master port.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have the following ports:
- clk, input, 1, sole clock; all logic updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- cmd_valid, input, 1, command request.
- cmd_ready, output, 1, command accepted when high together with cmd_valid.
- cmd_fill, input, 1, 1 = fill dst with cmd_pattern; 0 = copy src to dst.
- cmd_src, input, ADDR_W, source word address (copy only).
- cmd_dst, input, ADDR_W, destination word address.
- cmd_len, input, ADDR_W, word count; 0 = no transfer.
- cmd_pattern, input, DATA_W, fill word.
- abort, input, 1, stop at the next word boundary.
- busy, output, 1, high from the cycle after acceptance through DONE.
- done, output, 1, one-cycle completion pulse.
- aborted, output, 1, valid with done; 1 = terminated by abort.
- words_done, output, ADDR_W, count of words written.
- avm_address, output, ADDR_W, word address.
- avm_chipselect, output, 1, high whenever avm_read or avm_write is high.
- avm_read, output, 1, read strobe.
- avm_write, output, 1, write strobe.
- avm_byteenable, output, DATA_W/8, constant all-ones.
- avm_writedata, output, DATA_W, write data.
- avm_readdata, input, DATA_W, read data; fixed latency of 1 cycle.
- avm_waitrequest, input, 1, slave stall.

Function
REQ-005 SHALL implement states IDLE, RD, RDWAIT, WR and DONE.
REQ-006 IDLE: cmd_ready=1 in IDLE only. On cmd_valid, latch src, dst, len, fill and pattern, and clear words_done. Next state: DONE if len=0; else WR if fill; else RD.
REQ-007 RD: assert avm_read and avm_chipselect with avm_address=src_ptr. Hold these until a cycle with avm_waitrequest=0. In that cycle, increment src_ptr and go to RDWAIT.
REQ-008 RDWAIT: no strobes asserted. Capture avm_readdata into the data register, then go to WR.
REQ-009 WR: assert avm_write and avm_chipselect with avm_address=dst_ptr. avm_writedata = pattern if fill, else the data register. Address and data SHALL stay stable while avm_waitrequest=1.
REQ-010 On WR acceptance (avm_waitrequest=0): increment dst_ptr and words_done, decrement remaining. Next state: DONE if remaining was 1 or abort=1; else WR if fill; else RD.
REQ-011 DONE: done=1 for exactly one cycle. aborted=1 if the job ended by abort before remaining reached 0. Next state is IDLE.
REQ-012 abort SHALL be sampled only in WR on acceptance, and in RD on acceptance. An accepted read SHALL still complete its write before DONE.
REQ-013 abort in IDLE or DONE SHALL be ignored. cmd_valid outside IDLE SHALL be ignored.
REQ-014 src_ptr and dst_ptr SHALL wrap modulo 2^ADDR_W.
REQ-015 avm_read and avm_write SHALL never be high in the same cycle.
REQ-016 Zero-wait throughput SHALL be 1 word/cycle for fill and 1 word per 3 cycles for copy.
REQ-017 Latency, with acceptance at cycle T and no waits:
- Fill, len=1: write at T+1, done at T+2.
- Copy, len=1: read at T+1, capture at T+2, write at T+3, done at T+4.
REQ-018 words_done and aborted SHALL hold their values after DONE until the next command is accepted.

Reset
REQ-019 On reset, the block SHALL take effect at the next rising edge: state=IDLE, all strobes=0, done=0, aborted=0, busy=0, words_done=0, pointers=0. cmd_ready SHALL be 1 from the first cycle after reset.
REQ-020 Reset mid-transfer SHALL abandon the job immediately without a done pulse, even with a strobe pending under waitrequest.

Verification
REQ-021 Fill: dst=0x0010, len=4, pattern=0xDEADBEEF, no waits -> writes to 0x10..0x13 on 4 consecutive cycles; done at T+5; words_done=4; aborted=0.
REQ-022 Copy: src=0x0100 preloaded with 0x11111111/0x22222222, dst=0x0200, len=2 -> reads 0x100 and 0x101 each followed by a write of the same data; done at T+7; memory 0x200/0x201 matches.
REQ-023 Waitrequest held 3 cycles on the first read and 2 cycles on the first write -> address and data stable throughout; each access issued exactly once; result identical to REQ-022.
REQ-024 Wrap: fill dst=0xFFFE, len=3 -> writes to 0xFFFE, 0xFFFF, 0x0000.
REQ-025 Boundary: len=0 -> no strobes, done at T+1, words_done=0. abort asserted during the 2nd write of a len=8 copy -> 2 words written, done with aborted=1.
REQ-026 Reset asserted in WR with waitrequest=1 -> next cycle all strobes=0, cmd_ready=1, no done pulse.
